// File: rtl/bp_inflight_queue.sv
// In-flight branch queue: records {prediction, PHT index} per fetched branch, trains the
// predictor at commit and restores speculative history on a mispredict.
module bp_inflight_queue #(
  parameter int DEPTH     = 16,
  parameter int GHR_DEPTH = 30,
  parameter int PHT_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic                 fetch_is_br,
  input  logic [31:0]          fetch_pc,
  input  logic                 pred_take,
  output logic                 fetch_ready,
  output logic [GHR_DEPTH-1:0] spec_ghr,
  input  logic                 rob_pop,
  input  logic [6:0]           commit_opcode,
  input  logic                 commit_take,
  output logic                 upd_valid,
  output logic [PHT_DEPTH-1:0] upd_idx,
  output logic                 upd_take,
  output logic                 flush_branch,
  output logic                 underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic                 take;
    logic [PHT_DEPTH-1:0] idx;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW:0]          count_q, count_d;
  logic [GHR_DEPTH-1:0] spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
  logic                 upd_valid_q, upd_take_q, flush_q, underflow_q, underflow_d;
  logic [PHT_DEPTH-1:0] upd_idx_q;

  logic                 br_commit, pop, mispredict, push;
  entry_t               head_entry, push_entry;
  logic                 unused_bits;

  assign unused_bits = ^{fetch_pc[31:PHT_DEPTH+2], fetch_pc[1:0], arch_ghr_q[GHR_DEPTH-1]};

  assign fetch_ready = (count_q != FULL_CNT);
  assign head_entry  = mem_q[head_q];
  assign br_commit   = rob_pop && (commit_opcode == OP_BRANCH);
  assign pop         = br_commit && (count_q != '0);
  assign mispredict  = pop && (head_entry.take != commit_take);
  assign push        = fetch_valid && fetch_is_br && fetch_ready && !mispredict;

  assign push_entry.take = pred_take;
  assign push_entry.idx  = spec_ghr_q[PHT_DEPTH-1:0] ^ fetch_pc[PHT_DEPTH+1:2];

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    spec_ghr_d  = spec_ghr_q;
    arch_ghr_d  = arch_ghr_q;
    underflow_d = underflow_q;

    if (pop) begin
      arch_ghr_d = {arch_ghr_q[GHR_DEPTH-2:0], commit_take};
    end
    if (br_commit && (count_q == '0)) begin
      underflow_d = 1'b1;
    end

    // A mispredict wins over everything: queue collapses and history rolls back to the
    // architectural path extended by the resolved outcome.
    if (mispredict) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      spec_ghr_d = {arch_ghr_q[GHR_DEPTH-2:0], commit_take};
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push) begin
        tail_d     = tail_q + 1'b1;
        spec_ghr_d = {spec_ghr_q[GHR_DEPTH-2:0], pred_take};
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
      underflow_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_take_q  <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      spec_ghr_q  <= spec_ghr_d;
      arch_ghr_q  <= arch_ghr_d;
      underflow_q <= underflow_d;
      upd_valid_q <= pop;
      upd_idx_q   <= pop ? head_entry.idx : '0;
      upd_take_q  <= pop && commit_take;
      flush_q     <= mispredict;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  assign spec_ghr     = spec_ghr_q;
  assign upd_valid    = upd_valid_q;
  assign upd_idx      = upd_idx_q;
  assign upd_take     = upd_take_q;
  assign flush_branch = flush_q;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_bp_inflight_queue.sv
// Directed bench for bp_inflight_queue: a hand-computed vector table followed by
// sequences for full, flush, reset-mid-operation and pointer wrap.
module tb_bp_inflight_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_is_br, pred_take;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [29:0] spec_ghr;
  logic        rob_pop, commit_take;
  logic [6:0]  commit_opcode;
  logic        upd_valid, upd_take, flush_branch, underflow;
  logic [9:0]  upd_idx;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  bp_inflight_queue #(.DEPTH(16), .GHR_DEPTH(30), .PHT_DEPTH(10)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_is_br(fetch_is_br), .fetch_pc(fetch_pc),
    .pred_take(pred_take), .fetch_ready(fetch_ready), .spec_ghr(spec_ghr),
    .rob_pop(rob_pop), .commit_opcode(commit_opcode), .commit_take(commit_take),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_take(upd_take),
    .flush_branch(flush_branch), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fv; logic br; logic [31:0] pc; logic pt;
    logic pop; logic [6:0] op; logic tk;
    logic rdy; logic [29:0] ghr; logic uv; logic [9:0] ui; logic ut; logic fl; logic uf;
  } vec_t;

  vec_t vecs [11];

  // Reference model for the longer sequences
  logic [29:0] mghr;
  logic [9:0]  qidx [$];
  logic        qpt  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic br, input logic [31:0] pc, input logic pt,
                       input logic pop, input logic [6:0] op, input logic tk);
    fetch_valid = fv; fetch_is_br = br; fetch_pc = pc; pred_take = pt;
    rob_pop = pop; commit_opcode = op; commit_take = tk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mghr = '0;
    qidx.delete();
    qpt.delete();
  endtask

  task automatic model_push(input logic [31:0] pc, input logic pt);
    qidx.push_back(mghr[9:0] ^ pc[11:2]);
    qpt.push_back(pt);
    mghr = {mghr[28:0], pt};
  endtask

  initial begin
    //           fv    br    pc         pt    pop   op   tk    rdy   ghr      uv    ui      ut    fl    uf
    vecs[0]  = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 7'h0, 1'b0, 1'b1, 30'h1, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 7'h0, 1'b0, 1'b1, 30'h2, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 7'h0, 1'b0, 1'b1, 30'h5, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, BR,   1'b1, 1'b1, 30'h5, 1'b1, 10'h004, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 7'h0, 1'b0, 1'b1, 30'h5, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, BR,   1'b0, 1'b1, 30'h5, 1'b1, 10'h009, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h44, 1'b1, 1'b1, ALU,  1'b1, 1'b1, 30'h5, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 7'h0, 1'b0, 1'b1, 30'h5, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b1, BR,   1'b0, 1'b1, 30'h4, 1'b1, 10'h00E, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, BR,   1'b1, 1'b1, 30'h4, 1'b0, 10'h0,  1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 7'h0, 1'b0, 1'b1, 30'h4, 1'b0, 10'h0,  1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    idle();
    step();
    step();
    check("reset_ghr", 32'(spec_ghr), 32'h0);
    check("reset_upd_valid", 32'(upd_valid), 32'h0);
    check("reset_upd_idx", 32'(upd_idx), 32'h0);
    check("reset_flush", 32'(flush_branch), 32'h0);
    check("reset_underflow", 32'(underflow), 32'h0);
    rst = 1'b0;
    step();
    check("ready_after_reset", 32'(fetch_ready), 32'h1);

    // Table: three pushes, two good commits, non-branch traffic, mispredict, empty commit
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fv, vecs[i].br, vecs[i].pc, vecs[i].pt, vecs[i].pop, vecs[i].op, vecs[i].tk);
      step();
      check($sformatf("v%0d_ready", i), 32'(fetch_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_ghr", i), 32'(spec_ghr), 32'(vecs[i].ghr));
      check($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].uv));
      check($sformatf("v%0d_upd_idx", i), 32'(upd_idx), 32'(vecs[i].ui));
      check($sformatf("v%0d_upd_take", i), 32'(upd_take), 32'(vecs[i].ut));
      check($sformatf("v%0d_flush", i), 32'(flush_branch), 32'(vecs[i].fl));
      check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
    end

    // Reset mid-operation: a commit under reset leaves no strobe; queue is emptied
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 7'h0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, BR, 1'b1);
    step();
    check("rst_mid_upd_valid", 32'(upd_valid), 32'h0);
    check("rst_mid_underflow", 32'(underflow), 32'h0);
    check("rst_mid_ghr", 32'(spec_ghr), 32'h0);
    rst = 1'b0;
    idle();
    step();
    check("rst_mid_ready", 32'(fetch_ready), 32'h1);
    check("rst_mid_no_strobe", 32'(upd_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, BR, 1'b1);
    step();
    check("rst_mid_emptied", 32'(underflow), 32'h1);
    check("rst_mid_emptied_uv", 32'(upd_valid), 32'h0);

    // Mispredict flush with a simultaneous push that must be dropped
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 7'h0, 1'b0);
      step();
    end
    check("flush_pre_ghr", 32'(spec_ghr), 32'hF);
    drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, BR, 1'b0);
    step();
    check("flush_flag", 32'(flush_branch), 32'h1);
    check("flush_upd_idx", 32'(upd_idx), 32'h040);
    check("flush_upd_take", 32'(upd_take), 32'h0);
    check("flush_ghr", 32'(spec_ghr), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, BR, 1'b1);
    step();
    check("flush_push_dropped", 32'(underflow), 32'h1);
    check("flush_next_uv", 32'(upd_valid), 32'h0);
    check("flush_clears", 32'(flush_branch), 32'h0);

    // Full queue behaviour
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 32'h400 + 32'(4 * i), i[0], 1'b0, 7'h0, 1'b0);
      model_push(32'h400 + 32'(4 * i), i[0]);
      step();
      if (i == 14) check("full_ready_at_15", 32'(fetch_ready), 32'h1);
    end
    check("full_ready", 32'(fetch_ready), 32'h0);
    check("full_ghr", 32'(spec_ghr), 32'(mghr));
    drive(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 7'h0, 1'b0);
    step();
    check("full_push_ghr", 32'(spec_ghr), 32'(mghr));
    check("full_push_ready", 32'(fetch_ready), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, BR, qpt[0]);
    step();
    check("full_pop_ready", 32'(fetch_ready), 32'h1);
    check("full_pop_idx", 32'(upd_idx), 32'(qidx[0]));
    void'(qidx.pop_front());
    void'(qpt.pop_front());
    drive(1'b1, 1'b1, 32'h600, 1'b1, 1'b1, BR, qpt[0]);
    step();
    check("pushpop_idx", 32'(upd_idx), 32'(qidx[0]));
    void'(qidx.pop_front());
    void'(qpt.pop_front());
    model_push(32'h600, 1'b1);
    check("pushpop_ready", 32'(fetch_ready), 32'h1);
    check("pushpop_ghr", 32'(spec_ghr), 32'(mghr));
    check("pushpop_flush", 32'(flush_branch), 32'h0);
    drive(1'b1, 1'b1, 32'h604, 1'b0, 1'b0, 7'h0, 1'b0);
    model_push(32'h604, 1'b0);
    step();
    check("refill_ready", 32'(fetch_ready), 32'h0);

    // Alternating push/pop across pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc;
      logic pt;
      pc = 32'h2000 + 32'(i * 52);
      pt = (i % 3 == 0);
      drive(1'b1, 1'b1, pc, pt, 1'b0, 7'h0, 1'b0);
      model_push(pc, pt);
      step();
      check($sformatf("wrap%0d_ghr", i), 32'(spec_ghr), 32'(mghr));
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, BR, qpt[0]);
      step();
      check($sformatf("wrap%0d_uv", i), 32'(upd_valid), 32'h1);
      check($sformatf("wrap%0d_idx", i), 32'(upd_idx), 32'(qidx[0]));
      check($sformatf("wrap%0d_take", i), 32'(upd_take), 32'(qpt[0]));
      check($sformatf("wrap%0d_flush", i), 32'(flush_branch), 32'h0);
      void'(qidx.pop_front());
      void'(qpt.pop_front());
    end
    idle();
    step();
    check("wrap_no_underflow", 32'(underflow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
